// File: rtl/multiword_add_arbiter_if.sv
// multiword_add_arbiter_if: request, operand and result bundle for the shared multi-word adder
interface multiword_add_arbiter_if #(parameter int WORDS = 4);
  logic [1:0] req_valid, req_ready;
  logic [32*WORDS-1:0] a0, b0, a1, b1;
  logic sub0, sub1;
  logic res_valid, res_ready, res_id, res_cout;
  logic [32*WORDS-1:0] res_sum;
  modport master (output req_valid, a0, b0, sub0, a1, b1, sub1, res_ready,
                  input req_ready, res_valid, res_id, res_sum, res_cout);
  modport slave (input req_valid, a0, b0, sub0, a1, b1, sub1, res_ready,
                 output req_ready, res_valid, res_id, res_sum, res_cout);
endinterface

// File: rtl/multiword_add_arbiter.sv
// multiword_add_arbiter: two-requester round-robin multi-word add/subtract over one 32-bit adder
module CarrySelectAdder_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [16:0] lo, hi0, hi1;
  always_comb begin
    lo  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin};
    hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    hi1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;
    {cout, sum} = lo[16] ? {hi1, lo[15:0]} : {hi0, lo[15:0]};
  end
endmodule

module multiword_add_arbiter #(parameter int WORDS = 4) (
  input logic clk,
  input logic rst_n,
  multiword_add_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [4:0] LAST = 5'(WORDS - 1);
  state_t state, state_nx;
  logic [4:0] k;
  logic last_grant, win, accept, carry, sub, id, cout_q, cin, add_cout;
  logic [32*WORDS-1:0] a, b, sum_q;
  logic [31:0] add_sum;
  always_comb begin
    win = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];
    bus.req_ready = (state == IDLE && rst_n && |bus.req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
    accept = |bus.req_ready;
    cin = (k == 5'd0) ? sub : carry;
    state_nx = (state == IDLE) ? (accept ? RUN : IDLE) :
               (state == RUN)  ? ((k == LAST) ? DONE : RUN) :
               (bus.res_ready ? IDLE : DONE);
    bus.res_valid = (state == DONE);
    bus.res_id = id;
    bus.res_sum = sum_q;
    bus.res_cout = cout_q;
  end
  CarrySelectAdder_32_bit u_add (
    .a(a[32*k +: 32]),
    .b(b[32*k +: 32] ^ {32{sub}}),
    .cin(cin),
    .sum(add_sum),
    .cout(add_cout)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      last_grant <= 1'b1;
      carry <= 1'b0;
      sub <= 1'b0;
      a <= '0;
      b <= '0;
      id <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a <= win ? bus.a1 : bus.a0;
        b <= win ? bus.b1 : bus.b0;
        sub <= win ? bus.sub1 : bus.sub0;
        id <= win;
        last_grant <= win;
        k <= '0;
        sum_q <= '0;
        cout_q <= 1'b0;
      end else if (state == RUN) begin
        sum_q[32*k +: 32] <= add_sum;
        carry <= add_cout;
        k <= (k == LAST) ? 5'd0 : k + 5'd1;
        if (k == LAST) cout_q <= add_cout;
      end
    end
  end
endmodule

// File: tb/tb_multiword_add_arbiter.sv
// tb_multiword_add_arbiter: directed checks of arbitration, word sequencing, backpressure and reset
module tb_multiword_add_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  multiword_add_arbiter_if #(.WORDS(2)) m2 ();
  multiword_add_arbiter_if #(.WORDS(1)) m1 ();
  multiword_add_arbiter #(.WORDS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(m2.slave));
  multiword_add_arbiter #(.WORDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(m1.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op2(input bit r, input logic [63:0] a, input logic [63:0] b, input logic s,
                     input logic [63:0] es, input logic ec);
    if (r) begin m2.a1 = a; m2.b1 = b; m2.sub1 = s; end
    else begin m2.a0 = a; m2.b0 = b; m2.sub0 = s; end
    m2.req_valid = r ? 2'b10 : 2'b01;
    #1 chk("grant", 64'(m2.req_ready), r ? 64'd2 : 64'd1);
    tick();
    chk("run_ready", 64'(m2.req_ready), 64'd0);
    m2.req_valid = 2'b00;
    m2.a0 = 64'hDEAD_BEEF_0BAD_F00D; m2.b0 = 64'h0123_4567_89AB_CDEF; m2.sub0 = ~s;
    m2.a1 = 64'hDEAD_BEEF_0BAD_F00D; m2.b1 = 64'h0123_4567_89AB_CDEF; m2.sub1 = ~s;
    chk("run_valid0", 64'(m2.res_valid), 64'd0);
    tick();
    chk("run_valid1", 64'(m2.res_valid), 64'd0);
    tick();
    chk("done_valid", 64'(m2.res_valid), 64'd1);
    chk("done_sum", m2.res_sum, es);
    chk("done_cout", 64'(m2.res_cout), 64'(ec));
    chk("done_id", 64'(m2.res_id), 64'(r));
    m2.res_ready = 1'b1;
    tick();
    chk("idle_valid", 64'(m2.res_valid), 64'd0);
    m2.res_ready = 1'b0;
  endtask

  initial begin
    int gr[4], gc[4], rid[4];
    logic [63:0] rs[4];
    int ng, nr;
    m2.req_valid = 2'b00; m2.a0 = '0; m2.b0 = '0; m2.a1 = '0; m2.b1 = '0;
    m2.sub0 = 1'b0; m2.sub1 = 1'b0; m2.res_ready = 1'b0;
    m1.req_valid = 2'b00; m1.a0 = '0; m1.b0 = '0; m1.a1 = '0; m1.b1 = '0;
    m1.sub0 = 1'b0; m1.sub1 = 1'b0; m1.res_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(m2.res_valid), 64'd0);
    chk("rst_id", 64'(m2.res_id), 64'd0);
    chk("rst_sum", m2.res_sum, 64'd0);
    chk("rst_cout", 64'(m2.res_cout), 64'd0);
    m2.req_valid = 2'b11;
    #1 chk("rst_ready", 64'(m2.req_ready), 64'd0);
    m2.req_valid = 2'b00;
    rst_n = 1'b1;
    op2(1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0);
    op2(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1);
    op2(1'b0, 64'd5, 64'd3, 1'b1, 64'd2, 1'b1);
    op2(1'b0, 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    // round robin from a fresh reset with both requesters always valid
    rst_n = 1'b0;
    tick();
    m2.a0 = 64'd1; m2.b0 = 64'd1; m2.sub0 = 1'b0;
    m2.a1 = 64'd10; m2.b1 = 64'd20; m2.sub1 = 1'b0;
    m2.res_ready = 1'b1;
    m2.req_valid = 2'b11;
    rst_n = 1'b1;
    #1;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      if (|m2.req_ready && ng < 4) begin gr[ng] = int'(m2.req_ready[1]); gc[ng] = c; ng++; end
      if (m2.res_valid && nr < 4) begin rid[nr] = int'(m2.res_id); rs[nr] = m2.res_sum; nr++; end
      if (nr == 4) m2.req_valid = 2'b00;
      tick();
    end
    m2.req_valid = 2'b00;
    m2.res_ready = 1'b0;
    chk("rr_grants", 64'(ng), 64'd4);
    chk("rr_results", 64'(nr), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant", 64'(gr[i]), 64'(i % 2));
      chk("rr_id", 64'(rid[i]), 64'(i % 2));
      chk("rr_sum", rs[i], (i % 2) ? 64'd30 : 64'd2);
      if (i > 0) chk("rr_spacing", 64'(gc[i] - gc[i-1]), 64'd4);
    end
    // backpressure on a requester-1 subtraction
    m2.a1 = 64'h0000_0001_0000_0000; m2.b1 = 64'd1; m2.sub1 = 1'b1;
    m2.req_valid = 2'b10;
    #1 chk("bp_grant", 64'(m2.req_ready), 64'd2);
    tick();
    m2.req_valid = 2'b11;
    #1 chk("bp_run_ready", 64'(m2.req_ready), 64'd0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(m2.res_valid), 64'd1);
      chk("bp_sum", m2.res_sum, 64'h0000_0000_FFFF_FFFF);
      chk("bp_cout", 64'(m2.res_cout), 64'd1);
      chk("bp_id", 64'(m2.res_id), 64'd1);
      chk("bp_ready", 64'(m2.req_ready), 64'd0);
      tick();
    end
    m2.res_ready = 1'b1;
    #1 chk("bp_last_valid", 64'(m2.res_valid), 64'd1);
    chk("bp_last_ready", 64'(m2.req_ready), 64'd0);
    tick();
    chk("bp_idle_valid", 64'(m2.res_valid), 64'd0);
    chk("bp_idle_grant", 64'(m2.req_ready), 64'd1);
    m2.req_valid = 2'b00;
    m2.res_ready = 1'b0;
    // reset in RUN word 1 abandons the op and restores requester-0 priority
    m2.a0 = 64'h1234_5678_9ABC_DEF0; m2.b0 = 64'h1111_1111_1111_1111; m2.sub0 = 1'b0;
    m2.req_valid = 2'b01;
    #1 chk("rs_grant", 64'(m2.req_ready), 64'd1);
    tick();
    m2.req_valid = 2'b00;
    tick();
    rst_n = 1'b0;
    tick();
    m2.req_valid = 2'b11;
    #1 chk("rs_valid", 64'(m2.res_valid), 64'd0);
    chk("rs_sum", m2.res_sum, 64'd0);
    chk("rs_cout", 64'(m2.res_cout), 64'd0);
    chk("rs_id", 64'(m2.res_id), 64'd0);
    chk("rs_ready", 64'(m2.req_ready), 64'd0);
    rst_n = 1'b1;
    #1 chk("rs_first_grant", 64'(m2.req_ready), 64'd1);
    tick();
    m2.req_valid = 2'b00;
    tick();
    tick();
    chk("rs_done_valid", 64'(m2.res_valid), 64'd1);
    chk("rs_done_sum", m2.res_sum, 64'h2345_6789_ABCD_F001);
    chk("rs_done_id", 64'(m2.res_id), 64'd0);
    m2.res_ready = 1'b1;
    tick();
    m2.res_ready = 1'b0;
    // single-word engine
    m1.a0 = 32'hFFFF_FFFF; m1.b0 = 32'hFFFF_FFFF; m1.sub0 = 1'b0;
    m1.req_valid = 2'b01;
    #1 chk("w1_grant", 64'(m1.req_ready), 64'd1);
    tick();
    m1.req_valid = 2'b00;
    chk("w1_run_valid", 64'(m1.res_valid), 64'd0);
    tick();
    chk("w1_valid", 64'(m1.res_valid), 64'd1);
    chk("w1_sum", 64'(m1.res_sum), 64'hFFFF_FFFE);
    chk("w1_cout", 64'(m1.res_cout), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
